full_adder: RTL and testbench

- Registered ripple-carry full adder: adds two WIDTH-bit operands plus a 1-bit carry-in and produces a WIDTH-bit sum and a carry-out.
- Built from a chain of 1-bit full-adder cells. With WIDTH=1 it is exactly the classic a/b/cin -> sum/carry full adder.
- Arithmetic leaf used by datapath blocks. Results are registered on clk with a valid flag.

---
 rtl/full_adder_if.sv | 24 ++
 rtl/full_adder.sv | 46 ++++
 tb/tb_full_adder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// master drives operands and samples results; slave is the adder itself.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid, a, b, c,
        input  s, c_out, ovf, out_valid
    );

    modport slave (
        input  in_valid, a, b, c,
        output s, c_out, ovf, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Ripple-carry adder of WIDTH 1-bit cells with registered sum, carry-out and signed overflow.
// One-cycle latency, one result per cycle; never stalls, no backpressure.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    full_adder_if.slave  bus
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;

    logic [WIDTH-1:0] s_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             out_valid_q;

    assign carry[0] = bus.c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum_comb[i]  = bus.a[i] ^ bus.b[i] ^ carry[i];
        assign carry[i+1]   = (bus.a[i] & bus.b[i]) | (carry[i] & (bus.a[i] ^ bus.b[i]));
    end

    // Result registers only load on valid operands, so idle-cycle inputs never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q     <= sum_comb;
                c_out_q <= carry[WIDTH];
                ovf_q   <= carry[WIDTH] ^ carry[WIDTH-1];
            end
        end
    end

    assign bus.s         = s_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_full_adder.sv
// Directed and randomized checks of full_adder at WIDTH 1, 4 and 8 against hand-computed values.
`timescale 1ns/1ps
module tb_full_adder;
    logic clk;
    logic rst;

    int n_tests;
    int n_fail;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(4)) if4 ();
    full_adder_if #(.WIDTH(8)) if8 ();

    full_adder #(.WIDTH(1)) u_fa1 (.clk(clk), .rst(rst), .bus(if1));
    full_adder #(.WIDTH(4)) u_fa4 (.clk(clk), .rst(rst), .bus(if4));
    full_adder #(.WIDTH(8)) u_fa8 (.clk(clk), .rst(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_s1;
        logic [7:0] exp_c1;
        logic [7:0] exp_o1;
        logic [2:0] abc;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] ref_sum;
        logic       ref_ovf;

        n_tests = 0;
        n_fail  = 0;
        exp_s1  = 8'b1001_0110;
        exp_c1  = 8'b1110_1000;
        exp_o1  = 8'b0100_0010;

        rst = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.c = 1'b0;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.c = 1'b0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.c = 1'b0;
        tick();
        tick();
        check("rst_w1", {if1.out_valid, if1.ovf, if1.c_out, if1.s}, 64'h0);
        check("rst_w4", {if4.out_valid, if4.ovf, if4.c_out, if4.s}, 64'h0);
        check("rst_w8", {if8.out_valid, if8.ovf, if8.c_out, if8.s}, 64'h0);
        rst = 1'b0;

        // WIDTH=1 exhaustive, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            if1.in_valid = 1'b1;
            if1.a = abc[2];
            if1.b = abc[1];
            if1.c = abc[0];
            tick();
            check($sformatf("w1_s_%0d", i),   if1.s,         exp_s1[i]);
            check($sformatf("w1_c_%0d", i),   if1.c_out,     exp_c1[i]);
            check($sformatf("w1_ovf_%0d", i), if1.ovf,       exp_o1[i]);
            check($sformatf("w1_vld_%0d", i), if1.out_valid, 1'b1);
        end

        rst = 1'b1;
        if1.in_valid = 1'b1; if1.a = 1'b1; if1.b = 1'b1; if1.c = 1'b1;
        tick();
        check("w1_rst_over_valid", {if1.out_valid, if1.ovf, if1.c_out, if1.s}, 64'h0);
        rst = 1'b0;
        if1.a = 1'b0; if1.b = 1'b1; if1.c = 1'b1;
        tick();
        check("w1_post_rst_s",   if1.s,         1'b0);
        check("w1_post_rst_c",   if1.c_out,     1'b1);
        check("w1_post_rst_vld", if1.out_valid, 1'b1);
        if1.in_valid = 1'b0;
        tick();
        check("w1_idle_vld", if1.out_valid, 1'b0);

        if4.in_valid = 1'b1; if4.a = 4'hF; if4.b = 4'h0; if4.c = 1'b1;
        tick();
        check("w4_wrap", {if4.out_valid, if4.ovf, if4.c_out, if4.s}, {1'b1, 1'b0, 1'b1, 4'h0});
        if4.a = 4'h7; if4.b = 4'h1; if4.c = 1'b0;
        tick();
        check("w4_ovf", {if4.out_valid, if4.ovf, if4.c_out, if4.s}, {1'b1, 1'b1, 1'b0, 4'h8});
        if4.a = 4'h3; if4.b = 4'h4; if4.c = 1'b0;
        tick();
        check("w4_hold_base", {if4.out_valid, if4.c_out, if4.s}, {1'b1, 1'b0, 4'h7});
        for (int i = 0; i < 3; i++) begin
            if4.in_valid = 1'b0;
            if4.a = 4'($urandom);
            if4.b = 4'($urandom);
            if4.c = 1'($urandom);
            tick();
            check($sformatf("w4_hold_s_%0d", i),   if4.s,         4'h7);
            check($sformatf("w4_hold_vld_%0d", i), if4.out_valid, 1'b0);
        end

        if8.in_valid = 1'b1; if8.a = 8'h80; if8.b = 8'h80; if8.c = 1'b0;
        tick();
        check("w8_neg_ovf", {if8.ovf, if8.c_out, if8.s}, {1'b1, 1'b1, 8'h00});
        if8.a = 8'hFF; if8.b = 8'hFF; if8.c = 1'b1;
        tick();
        check("w8_max", {if8.ovf, if8.c_out, if8.s}, {1'b0, 1'b1, 8'hFF});

        // 1000 back-to-back vectors, each checked one edge after it is applied
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ref_sum = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            ref_ovf = (ra[7] == rb[7]) && (ref_sum[7] != ra[7]);
            if8.in_valid = 1'b1; if8.a = ra; if8.b = rb; if8.c = rc;
            tick();
            check($sformatf("w8_rand_%0d", i),
                  {if8.out_valid, if8.ovf, if8.c_out, if8.s},
                  {1'b1, ref_ovf, ref_sum});
        end
        if8.in_valid = 1'b0;
        tick();
        check("w8_drain_vld", if8.out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
